stg_ifq: RTL and testbench
==========================

Name: stg_ifq

Overview:
- Instruction fetch queue sitting directly upstream of stg_xt.
- Buffers fetched {pc, instr} pairs from the fetch stage so fetch can keep running while stg_xt is stalled, busy expanding a macro (JSRui/BSR*/RET/KRET), or the pipeline is globally stalled.
- Presents one registered {pc, instr} pair per advance cycle on the exact signals stg_xt consumes (iw_pc/iw_instr).
- Emits a NOP bubble when it has nothing to issue.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- CW, $clog2(DEPTH+1), width of ow_count.

Ports:
- iw_clk  input  1  clock; all state updates on rising edge.
- iw_rst  input  1  synchronous, active-high reset.
- iw_flush  input  1  discard all queued and output state (branch redirect/exception).
- iw_stall  input  1  global pipeline stall; output held.
- iw_xt_busy  input  1  stg_xt mid-expansion; output held.
- iw_fetch_valid  input  1  fetch presents a valid pair this cycle.
- iw_fetch_pc  input  `HBIT_ADDR+1  pc of fetched instruction.
- iw_fetch_instr  input  `HBIT_DATA+1  fetched instruction word.
- ow_fetch_ready  output  1  queue accepts a pair this cycle (combinational).
- ow_pc  output  `HBIT_ADDR+1  registered pc to stg_xt.
- ow_instr  output  `HBIT_DATA+1  registered instruction to stg_xt.
- ow_valid  output  1  ow_instr is a real instruction (0 = bubble).
- ow_count  output  CW  entries currently held in the queue (excludes output register).

Behaviour:
- Storage: circular buffer of DEPTH entries with rd_ptr, wr_ptr (log2 DEPTH bits, wrap naturally) and count (0..DEPTH).
- ow_fetch_ready = !iw_flush && (count != DEPTH). No write-through when full: a pop in the same cycle does not make a full queue ready.
- wr = iw_fetch_valid && ow_fetch_ready. Fetch must hold its pair until accepted.
- adv = !iw_stall && !iw_xt_busy.
- Each rising edge, first matching row wins:
  - iw_rst: pointers=0, count=0, ow_pc=0, ow_instr={`OPC_NOP,16'b0}, ow_valid=0.
  - iw_flush: same as reset except ow_pc holds its value. Any fetch input this cycle is dropped.
  - adv && count>0: output <= head entry, ow_valid=1, rd_ptr++. If wr, push input at wr_ptr, wr_ptr++. Count changes by (wr - 1).
  - adv && count==0 && wr: bypass. Output <= {iw_fetch_pc, iw_fetch_instr}, ow_valid=1; nothing stored; count stays 0.
  - adv && count==0 && !wr: ow_instr={`OPC_NOP,16'b0}, ow_valid=0, ow_pc holds.
  - !adv: output registers hold. If wr, push; count++.
- Latency: an empty queue with adv=1 gives 1 cycle fetch->ow_instr. Otherwise strict FIFO order is preserved; never reorder, duplicate, or drop an accepted pair except on flush/reset.
- Stored instruction words are opaque: no opcode decode. BTP, macros, and HLT pass unmodified.
- Reset or flush mid-operation (queue partly full, xt busy) fully empties the queue within that one edge. ow_fetch_ready is 1 on the following cycle.
- count never exceeds DEPTH and never underflows (pops only when count>0).

Test Plan:
- Reset: iw_rst=1 for one edge with fetch_valid=1 -> ow_instr={`OPC_NOP,0}, ow_valid=0, ow_pc=0, ow_count=0, ow_fetch_ready=1 after release.
- Bypass: empty, adv=1, fetch {pc=0x000010, instr={`OPC_JCCui,4'hA,12'h123}} -> next edge ow_pc=0x000010, ow_instr equal, ow_valid=1, ow_count=0; next idle edge -> NOP, ow_valid=0.
- Fill while busy: iw_xt_busy=1, push pcs 0x20,0x21,0x22,0x23 (DEPTH=4) -> ow_count=4, ow_fifth push refused (ow_fetch_ready=0), output held. Release busy -> ow_pc 0x20,0x21,0x22,0x23 on four successive edges, then NOP.
- Simultaneous push/pop: count=2 (0x30,0x31), adv=1, push 0x32 -> output 0x30, count stays 2. Continue with no pushes -> 0x31, then 0x32.
- Flush: count=3, iw_flush=1 with fetch_valid=1 (pc 0x40) -> next cycle count=0, ow_valid=0, ow_instr=NOP, 0x40 not seen. Next push 0x50 bypasses to ow_pc=0x50.
- Stall: iw_stall=1 with output valid=0x60 for 3 edges while pushing 0x61,0x62 -> ow_pc stays 0x60, count=2. Release -> 0x61, 0x62.

Source files
------------

// File: rtl/stg_ifq.sv
// Instruction fetch queue ahead of stg_xt: buffers {pc, instr} pairs so fetch
// keeps running while xt is busy or the pipe is stalled; issues a bubble when empty.
`ifndef HBIT_ADDR
`define HBIT_ADDR 23
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef OPC_NOP
`define OPC_NOP 8'h00
`endif

module stg_ifq #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic                iw_flush,
  input  logic                iw_stall,
  input  logic                iw_xt_busy,
  input  logic                iw_fetch_valid,
  input  logic [`HBIT_ADDR:0] iw_fetch_pc,
  input  logic [`HBIT_DATA:0] iw_fetch_instr,
  output logic                ow_fetch_ready,
  output logic [`HBIT_ADDR:0] ow_pc,
  output logic [`HBIT_DATA:0] ow_instr,
  output logic                ow_valid,
  output logic [CW-1:0]       ow_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [`HBIT_DATA:0] NOP_WORD = {`OPC_NOP, 16'b0};

  logic [`HBIT_ADDR:0] mem_pc    [DEPTH];
  logic [`HBIT_DATA:0] mem_instr [DEPTH];
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic [CW-1:0]       count;
  logic                wr;
  logic                adv;
  logic                empty;
  logic                pop;
  logic                push;

  // No write-through when full: a same-cycle pop does not open a slot.
  assign ow_fetch_ready = !iw_flush && (count != FULL);
  assign wr             = iw_fetch_valid && ow_fetch_ready;
  assign adv            = !iw_stall && !iw_xt_busy;
  assign empty          = (count == '0);
  assign pop            = adv && !empty;
  // An accepted pair on an empty, advancing queue bypasses storage.
  assign push           = wr && !(adv && empty);
  assign ow_count       = count;

  always_ff @(posedge iw_clk) begin
    if (push && !iw_rst) begin
      mem_pc[wr_ptr]    <= iw_fetch_pc;
      mem_instr[wr_ptr] <= iw_fetch_instr;
    end
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ow_pc    <= '0;
      ow_instr <= NOP_WORD;
      ow_valid <= 1'b0;
    end else if (iw_flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ow_instr <= NOP_WORD;
      ow_valid <= 1'b0;
    end else begin
      if (adv) begin
        if (!empty) begin
          ow_pc    <= mem_pc[rd_ptr];
          ow_instr <= mem_instr[rd_ptr];
          ow_valid <= 1'b1;
          rd_ptr   <= rd_ptr + 1'b1;
        end else if (wr) begin
          ow_pc    <= iw_fetch_pc;
          ow_instr <= iw_fetch_instr;
          ow_valid <= 1'b1;
        end else begin
          ow_instr <= NOP_WORD;
          ow_valid <= 1'b0;
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stg_ifq.sv
// Self-checking bench for stg_ifq: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
`ifndef HBIT_ADDR
`define HBIT_ADDR 23
`endif
`ifndef HBIT_DATA
`define HBIT_DATA 23
`endif
`ifndef OPC_NOP
`define OPC_NOP 8'h00
`endif
`ifndef OPC_JCCui
`define OPC_JCCui 8'h2C
`endif

module tb_stg_ifq;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [23:0] NOP_W = {`OPC_NOP, 16'b0};
  localparam logic [23:0] JCC_W = {`OPC_JCCui, 4'hA, 12'h123};

  logic clk = 1'b0;
  logic rst, flush, stall, busy, fv;
  logic [23:0] fpc, finstr;
  logic ready, valid;
  logic [23:0] opc, oinstr;
  logic [CW-1:0] cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [47:0] q[$];
  logic [23:0] m_pc, m_instr;
  logic m_valid;
  logic m_acc;

  always #5 clk = ~clk;

  stg_ifq #(.DEPTH(DEPTH)) dut (
    .iw_clk(clk), .iw_rst(rst), .iw_flush(flush), .iw_stall(stall),
    .iw_xt_busy(busy), .iw_fetch_valid(fv), .iw_fetch_pc(fpc),
    .iw_fetch_instr(finstr), .ow_fetch_ready(ready), .ow_pc(opc),
    .ow_instr(oinstr), .ow_valid(valid), .ow_count(cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [23:0] pc, input logic [23:0] ins,
                       input logic s, input logic b, input logic f, input logic r);
    fv = v; fpc = pc; finstr = ins; stall = s; busy = b; flush = f; rst = r;
  endtask

  // One clock: check ready before the edge, step the model, check outputs after.
  task automatic cyc();
    logic wr;
    @(negedge clk);
    if (!rst) chk("ready", 32'(ready), 32'(!flush && q.size() < DEPTH));
    wr = fv && !flush && q.size() < DEPTH;
    m_acc = wr && !rst;
    if (rst) begin
      q.delete(); m_pc = '0; m_instr = NOP_W; m_valid = 1'b0;
    end else if (flush) begin
      q.delete(); m_instr = NOP_W; m_valid = 1'b0;
    end else begin
      if (wr) q.push_back({fpc, finstr});
      if (!stall && !busy) begin
        if (q.size() > 0) begin
          {m_pc, m_instr} = q.pop_front();
          m_valid = 1'b1;
        end else begin
          m_instr = NOP_W; m_valid = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("valid", 32'(valid), 32'(m_valid));
    chk("instr", 32'(oinstr), 32'(m_instr));
    chk("pc", 32'(opc), 32'(m_pc));
    chk("count", 32'(cnt), 32'(q.size()));
  endtask

  initial begin
    logic [23:0] rpc, rins;
    m_pc = '0; m_instr = NOP_W; m_valid = 1'b0; m_acc = 1'b0;
    drive(1, 24'h5, 24'h5, 0, 0, 0, 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_pc", 32'(opc), 0);
    chk("rst_instr", 32'(oinstr), 32'(NOP_W));
    chk("rst_count", 32'(cnt), 0);
    #1 chk("rst_ready", 32'(ready), 1);

    // bypass
    drive(1, 24'h10, JCC_W, 0, 0, 0, 0); cyc();
    chk("byp_pc", 32'(opc), 32'h10);
    chk("byp_instr", 32'(oinstr), 32'(JCC_W));
    chk("byp_valid", 32'(valid), 1);
    chk("byp_count", 32'(cnt), 0);
    drive(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("byp_idle", 32'(valid), 0);

    // fill while busy
    for (int i = 0; i < 4; i++) begin
      drive(1, 24'h20 + 24'(i), 24'h1000 + 24'(i), 0, 1, 0, 0); cyc();
    end
    chk("fill_count", 32'(cnt), 4);
    drive(1, 24'h24, 24'h1004, 0, 1, 0, 0);
    #1 chk("full_ready", 32'(ready), 0);
    cyc();
    chk("full_hold", 32'(cnt), 4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0); cyc();
      chk("drain_pc", 32'(opc), 32'h20 + i);
    end
    cyc();
    chk("drain_nop", 32'(valid), 0);

    // simultaneous push/pop
    drive(1, 24'h30, 24'h2000, 0, 1, 0, 0); cyc();
    drive(1, 24'h31, 24'h2001, 0, 1, 0, 0); cyc();
    drive(1, 24'h32, 24'h2002, 0, 0, 0, 0); cyc();
    chk("pp_pc", 32'(opc), 32'h30);
    chk("pp_count", 32'(cnt), 2);
    drive(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("pp_pc1", 32'(opc), 32'h31);
    cyc();
    chk("pp_pc2", 32'(opc), 32'h32);

    // flush
    for (int i = 0; i < 3; i++) begin
      drive(1, 24'h3A + 24'(i), 24'h3000 + 24'(i), 0, 1, 0, 0); cyc();
    end
    drive(1, 24'h40, 24'h4000, 0, 1, 1, 0); cyc();
    chk("fl_count", 32'(cnt), 0);
    chk("fl_valid", 32'(valid), 0);
    chk("fl_instr", 32'(oinstr), 32'(NOP_W));
    drive(1, 24'h50, 24'h5000, 0, 0, 0, 0); cyc();
    chk("fl_byp", 32'(opc), 32'h50);

    // stall
    drive(1, 24'h60, 24'h6000, 0, 0, 0, 0); cyc();
    drive(1, 24'h61, 24'h6001, 1, 0, 0, 0); cyc();
    drive(1, 24'h62, 24'h6002, 1, 0, 0, 0); cyc();
    drive(0, 0, 0, 1, 0, 0, 0); cyc();
    chk("st_pc", 32'(opc), 32'h60);
    chk("st_count", 32'(cnt), 2);
    drive(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("st_pc1", 32'(opc), 32'h61);
    cyc();
    chk("st_pc2", 32'(opc), 32'h62);

    // random traffic; fetch holds its pair until accepted
    rpc = 24'($urandom); rins = 24'($urandom);
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 3) != 0, rpc, rins,
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
      cyc();
      if (m_acc) begin
        rpc = 24'($urandom); rins = 24'($urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
